// File: rtl/unibus_master_if.sv
// unibus_master_if: Unibus-style address/data/control and MSYN/SSYN handshake
interface unibus_master_if;
    logic [17:0] bus_addr;
    logic [15:0] bus_d_out;
    logic [15:0] bus_d_in;
    logic        bus_msyn;
    logic        bus_ssyn;
    logic        bus_c0;
    logic        bus_c1;
    logic        bus_init;
    modport master (
        output bus_addr, bus_d_out, bus_msyn, bus_c0, bus_c1,
        input  bus_d_in, bus_ssyn, bus_init
    );
    modport slave (
        input  bus_addr, bus_d_out, bus_msyn, bus_c0, bus_c1, bus_init,
        output bus_d_in, bus_ssyn
    );
endinterface

// File: rtl/unibus_master.sv
// unibus_master: runs one DATI/DATO/DATOB bus cycle per CPU request with SSYN timeout
module unibus_master #(
    parameter int SETUP_CYC   = 4,
    parameter int HOLD_CYC    = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [17:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    unibus_master_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [2:0] {IDLE, SETUP, WAIT_S, WAIT_NS, HOLD} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic we, byt, pend, pend_n, done_n, err_n, take, grab, busy;
    assign busy  = state != IDLE;
    assign ready = (state == IDLE) & ~bus.bus_init;
    assign take  = req & ready;
    // outputs decode straight from state so an async reset clears the bus at once
    assign bus.bus_addr  = busy ? addr : '0;
    assign bus.bus_d_out = (busy & we) ? wdata : '0;
    assign bus.bus_c1    = busy & we;
    assign bus.bus_c0    = busy & we & byt;
    assign bus.bus_msyn  = state == WAIT_S;
    always_comb begin
        state_n = state;
        cnt_n   = (cnt == CW'(TIMEOUT_CYC)) ? cnt : cnt + 1'b1;
        pend_n  = pend;
        done_n  = 1'b0;
        err_n   = 1'b0;
        grab    = 1'b0;
        if (busy && bus.bus_init) begin
            state_n = IDLE;
            done_n  = 1'b1;
            err_n   = 1'b1;
        end else begin
            case (state)
                IDLE: if (take) begin
                    state_n = SETUP;
                    cnt_n   = '0;
                    pend_n  = 1'b0;
                end
                SETUP: if (cnt == CW'(SETUP_CYC - 1)) begin
                    state_n = WAIT_S;
                    cnt_n   = '0;
                end
                WAIT_S: if (bus.bus_ssyn) begin
                    state_n = WAIT_NS;
                    cnt_n   = '0;
                    pend_n  = 1'b0;
                    grab    = ~we;
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    state_n = WAIT_NS;
                    cnt_n   = '0;
                    pend_n  = 1'b1;
                end
                WAIT_NS: if (!bus.bus_ssyn || cnt == CW'(TIMEOUT_CYC - 1)) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                    pend_n  = pend | bus.bus_ssyn;
                end
                HOLD: if (cnt == CW'(HOLD_CYC - 1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    err_n   = pend;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            addr  <= '0;
            wdata <= '0;
            we    <= 1'b0;
            byt   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pend  <= pend_n;
            done  <= done_n;
            err   <= err_n;
            if (take) begin
                addr  <= req_addr;
                wdata <= req_wdata;
                we    <= req_we;
                byt   <= req_byte;
            end
            if (grab) rdata <= bus.bus_d_in;
        end
    end
endmodule

// File: doc/unibus_master.md
Name: unibus_master

Overview:
- Bus-initiator end of the Unibus-style handshake used by the on-chip memory and peripheral responders.
- Takes single-word/byte read and write requests from the CPU side and runs one DATI, DATO or DATOB cycle per request: address/control setup, MSYN assertion, SSYN wait with bus timeout, then MSYN/SSYN release and hold.
- Returns read data, completion and a non-existent-memory error to the requester.

Parameters:
SETUP_CYC, 4, clocks address/control/data are driven before MSYN rises (deskew); min 1
HOLD_CYC, 2, clocks address/control/data stay driven after SSYN falls; min 1
TIMEOUT_CYC, 1024, clocks to wait for an SSYN edge before declaring a bus error; must exceed slowest responder latency (memory: 16)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
req  input  1  request strobe; sampled only when ready=1
req_we  input  1  1=write (DATO/DATOB), 0=read (DATI)
req_byte  input  1  1=byte write (DATOB); ignored for reads
req_addr  input  18  byte address
req_wdata  input  16  write data; byte at addr[0]=1 must be on [15:8]
ready  output  1  block idle and able to accept req
done  output  1  one-clock pulse: cycle finished (success or error)
err  output  1  valid with done: 1=SSYN timeout (NXM) or bus_init abort
rdata  output  16  read data; valid from done until next accepted read
bus_init  input  1  bus init; aborts any cycle
bus_addr  output  18  bus address
bus_d_out  output  16  bus data driven by master (writes only)
bus_d_in  input  16  bus data from responders
bus_msyn  output  1  master sync
bus_ssyn  input  1  slave sync
bus_c0  output  1  control bit 0 (byte)
bus_c1  output  1  control bit 1 (write)

Behaviour:
- Reset (reset=0, async): state IDLE; counters 0; ready=1; done=0; err=0; rdata=0; all bus outputs 0.
- Bus outputs are 0 whenever not in a cycle (wired-OR bus). bus_d_out is nonzero only during write cycles.
- Encoding: DATI c1=0 c0=0; DATO c1=1 c0=0; DATOB c1=1 c0=1. bus_addr=req_addr unchanged, bit 0 included.
- ready = (state==IDLE) & ~bus_init.
- IDLE: on req & ready, register addr/wdata/we/byte, drive the bus outputs from the next clock, go to SETUP and load the counter. req while not ready is ignored.
- SETUP: hold for SETUP_CYC clocks, then assert bus_msyn and go to WAIT_S.
- WAIT_S: counter counts up.
  - On bus_ssyn=1: for reads, latch rdata<=bus_d_in in that clock. Drop bus_msyn next clock and go to WAIT_NS. err_pending=0.
  - If the count reaches TIMEOUT_CYC without SSYN: drop bus_msyn, set err_pending=1, go to WAIT_NS.
- WAIT_NS: wait for bus_ssyn=0, or TIMEOUT_CYC clocks (err_pending=1 on timeout). Then go to HOLD.
  - For writes, address, data and c1/c0 stay stable throughout; the responder writes while msyn&ssyn&c1.
- HOLD: keep address/data/control for HOLD_CYC clocks, then clear all bus outputs. Pulse done=1 with err=err_pending. Return to IDLE; ready=1 in the same clock as done.
- Minimum request-to-done latency: SETUP_CYC + responder delay + SSYN-release time + HOLD_CYC + fixed state overhead (≤4 clocks).
- Back-to-back: a req presented in the done clock is accepted. MSYN is never re-asserted until SSYN from the previous cycle has been seen low or timed out.
- bus_init=1 in any non-IDLE state:
  - next clock: all bus outputs 0 and done=1 with err=1, state IDLE;
  - rdata unchanged;
  - while bus_init stays high, ready=0 and no cycle starts.
- SSYN already high at MSYN assertion (stale responder) is accepted as a response; no special case.
- Counter width: clog2(TIMEOUT_CYC+1); saturates, never wraps.

Test Plan:
- Word read: memory-model responder, SSYN 16 clocks after MSYN, word 0o001000=0o123456; read addr 0o002000 -> done, err=0, rdata=0o123456; bus_msyn high ≥16 clocks; addr driven SETUP_CYC clocks before MSYN.
- Word write: req_we=1, addr 0o000100, wdata 0o177777 -> c1=1 c0=0 while msyn; model word 0o40=0o177777; done err=0.
- Byte write odd: addr 0o000101, req_byte=1, wdata 0o052400, word preset 0 -> c0=1; model word=0o052400 (high byte only); low byte stays 0.
- NXM: read addr 0o760000, no responder -> bus_msyn drops after TIMEOUT_CYC clocks; done with err=1; rdata keeps the previous value.
- bus_init during WAIT_S of a write -> next clock all bus outputs 0, done err=1, ready=0 until bus_init falls; a following read then succeeds.
- Async reset (reset=0) mid-SETUP -> bus outputs 0 immediately without a clock edge; after release ready=1 and no spurious done.
